// File: rtl/lsu_stage_param_pkg.sv
// Shared definitions for the memory-stage load/store unit: access size codes,
// FSM state encodings and the natural-alignment rule.
package lsu_stage_param_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    // A dword access is only meaningful when the cache word is 64 bits wide.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input int unsigned data_w);
        logic [2:0] low_mask;
        low_mask = 3'((4'd1 << size) - 4'd1);
        return ((addr_lo & low_mask) != 3'd0) || (size == SZ_D && data_w < 64);
    endfunction

endpackage

// File: rtl/lsu_stage_param_if.sv
// Request, data-cache and writeback signals of the load/store unit.
// The unit itself connects through the slave modport.
interface lsu_stage_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [REG_W-1:0]      req_rd;

    logic                  dcache_re;
    logic [DATA_W/8-1:0]   dcache_we;
    logic [ADDR_W-1:0]     dcache_addr;
    logic [DATA_W-1:0]     dcache_din;
    logic                  dcache_stall;
    logic [DATA_W-1:0]     dcache_dout;

    logic                  wb_valid;
    logic [REG_W-1:0]      wb_rd;
    logic [DATA_W-1:0]     wb_data;

    logic                  misalign;
    logic [ADDR_W-1:0]     misalign_addr;
    logic                  Stall;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  dcache_stall, dcache_dout,
        output req_ready,
        output dcache_re, dcache_we, dcache_addr, dcache_din,
        output wb_valid, wb_rd, wb_data,
        output misalign, misalign_addr, Stall
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output dcache_stall, dcache_dout,
        input  req_ready,
        input  dcache_re, dcache_we, dcache_addr, dcache_din,
        input  wb_valid, wb_rd, wb_data,
        input  misalign, misalign_addr, Stall
    );

endinterface

// File: rtl/lsu_stage_param_lane_align.sv
// Combinational lane steering: store data replication and byte-enable mask,
// and load field extraction with sign/zero extension.
module lsu_stage_param_lane_align #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    localparam int unsigned NB        = DATA_W / 8,
    localparam int unsigned OFF_W     = $clog2(DATA_W / 8)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] din,
    output logic [NB-1:0]     mask,
    output logic [DATA_W-1:0] ldata
);

    always_comb begin
        int unsigned n;
        int unsigned a;
        int unsigned k;
        logic [DATA_W-1:0] fld;
        logic sgn;
        n = 32'd1 << size;
        if (n > NB) n = NB;
        a = '0;
        k = '0;
        din = '0;
        mask = '0;
        fld = '0;
        // p walks physical lanes; a is the byte address offset that lane holds.
        for (int unsigned p = 0; p < NB; p++) begin
            din[8*p +: 8] = wdata[8*(p & (n - 1)) +: 8];
            a = BIG_ENDIAN ? (NB - 1 - p) : p;
            if (a >= 32'(off) && a < 32'(off) + n) begin
                k = a - 32'(off);
                mask[p] = 1'b1;
                if (BIG_ENDIAN) fld[8*(n-1-k) +: 8] = rdata[8*p +: 8];
                else            fld[8*k +: 8]       = rdata[8*p +: 8];
            end
        end
        sgn = !is_unsigned && fld[8*n-1];
        ldata = fld;
        for (int unsigned p = 0; p < NB; p++) begin
            if (p >= n) ldata[8*p +: 8] = {8{sgn}};
        end
    end

endmodule

// File: rtl/lsu_stage_param.sv
// MIPS150 memory-stage load/store unit: request latch, issue/wait/done FSM,
// misalignment trap and dcache stall handshake.
module lsu_stage_param
    import lsu_stage_param_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_W      = 5,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic             CLK,
    input  logic             reset,
    lsu_stage_param_if.slave bus
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [2:0]        state;
    logic              we_r;
    logic              uns_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [REG_W-1:0]  rd_r;
    logic [REG_W-1:0]  wb_rd_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [ADDR_W-1:0] misalign_addr_r;

    logic [DATA_W-1:0] din_w;
    logic [DATA_W-1:0] ldata_w;
    logic [NB-1:0]     mask_w;
    logic              bad;

    assign bad = is_misaligned(bus.req_addr[2:0], bus.req_size, DATA_W);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state           <= ST_IDLE;
            we_r            <= 1'b0;
            uns_r           <= 1'b0;
            size_r          <= SZ_B;
            addr_r          <= '0;
            wdata_r         <= '0;
            rd_r            <= '0;
            wb_rd_r         <= '0;
            wb_data_r       <= '0;
            misalign_addr_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_r    <= bus.req_we;
                        uns_r   <= bus.req_unsigned;
                        size_r  <= bus.req_size;
                        addr_r  <= bus.req_addr;
                        wdata_r <= bus.req_wdata;
                        rd_r    <= bus.req_rd;
                        if (bad) begin
                            misalign_addr_r <= bus.req_addr;
                            state           <= ST_FAULT;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: if (!bus.dcache_stall) state <= we_r ? ST_IDLE : ST_WAIT;
                ST_WAIT: begin
                    if (!bus.dcache_stall) begin
                        wb_data_r <= ldata_w;
                        wb_rd_r   <= rd_r;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Steering works from the latched request so cache outputs stay frozen under stall.
    lsu_stage_param_lane_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .off         (addr_r[OFF_W-1:0]),
        .size        (size_r),
        .is_unsigned (uns_r),
        .wdata       (wdata_r),
        .rdata       (bus.dcache_dout),
        .din         (din_w),
        .mask        (mask_w),
        .ldata       (ldata_w)
    );

    assign bus.req_ready     = (state == ST_IDLE);
    assign bus.Stall         = (state != ST_IDLE);
    assign bus.dcache_re     = (state == ST_ISSUE) && !we_r;
    assign bus.dcache_we     = (state == ST_ISSUE && we_r) ? mask_w : '0;
    assign bus.dcache_addr   = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.dcache_din    = din_w;
    assign bus.wb_valid      = (state == ST_DONE);
    assign bus.wb_rd         = wb_rd_r;
    assign bus.wb_data       = wb_data_r;
    assign bus.misalign      = (state == ST_FAULT);
    assign bus.misalign_addr = misalign_addr_r;

endmodule
